mesh_feeder: RTL



---
 rtl/mesh_pkg.sv | 21 ++
 rtl/tile_buffer.sv | 64 ++++++
 rtl/mesh_feeder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mesh_pkg.sv
// Shared types and helpers for the mesh operand feeder.
package mesh_pkg;

    localparam int unsigned DEFAULT_N = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_t;

    function automatic int unsigned stream_beats(input int unsigned n);
        return 2 * n - 1;
    endfunction

    // Beat counter width; holds 0 .. 2N-2.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(stream_beats(n));
    endfunction

endpackage

// File: rtl/tile_buffer.sv
// One N x N operand tile: row-write port, loaded bitmap and skewed diagonal read.
module tile_buffer
    import mesh_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          TRANSPOSE  = 1'b0,
    parameter int unsigned ROW_W      = $clog2(N),
    parameter int unsigned CNT_W      = cnt_width(N)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  we_i,
    input  logic [ROW_W-1:0]      row_i,
    input  logic [DATA_WIDTH-1:0] data_i [N],
    input  logic                  clr_i,
    input  logic [CNT_W-1:0]      t_i,
    output logic [N-1:0]          loaded_o,
    output logic [DATA_WIDTH-1:0] diag_o [N]
);

    logic [DATA_WIDTH-1:0] rows_q [N][N];
    logic [N-1:0]          loaded_q;

    // Tile storage is intentionally not reset; out-of-range rows match nothing.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < N; r++) begin
            if (we_i && row_i == ROW_W'(r)) begin
                rows_q[r] <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            loaded_q <= '0;
        end else if (clr_i) begin
            loaded_q <= '0;
        end else begin
            for (int r = 0; r < N; r++) begin
                if (we_i && row_i == ROW_W'(r)) begin
                    loaded_q[r] <= 1'b1;
                end
            end
        end
    end

    assign loaded_o = loaded_q;

    // Lane i carries element (i, t-i), or (t-i, i) when read transposed.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            diag_o[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(t_i) == i + j) begin
                    diag_o[i] = TRANSPOSE ? rows_q[j][i] : rows_q[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/mesh_feeder.sv
// Buffers an A/B operand tile pair and streams it into the systolic mesh with diagonal skew.
module mesh_feeder
    import mesh_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic                   load_sel_i,
    input  logic [$clog2(N)-1:0]   load_row_i,
    input  logic [DATA_WIDTH-1:0]  load_data_i [N],
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  west_o [N],
    output logic [DATA_WIDTH-1:0]  north_o [N],
    output logic                   inputs_valid_o
);

    localparam int unsigned ROW_W = $clog2(N);
    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(stream_beats(N) - 1);

    feeder_state_t         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  clr;
    logic                  load_we;
    logic [N-1:0]          loaded_a, loaded_b;
    logic [DATA_WIDTH-1:0] diag_a [N];
    logic [DATA_WIDTH-1:0] diag_b [N];

    assign load_we = load_valid_i && load_ready_o;

    // Tiles are read at the beat about to be registered onto the outputs.
    tile_buffer #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .TRANSPOSE(1'b0), .ROW_W(ROW_W), .CNT_W(CNT_W)
    ) u_tile_a (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .we_i     (load_we && !load_sel_i),
        .row_i    (load_row_i),
        .data_i   (load_data_i),
        .clr_i    (clr),
        .t_i      (cnt_d),
        .loaded_o (loaded_a),
        .diag_o   (diag_a)
    );

    tile_buffer #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .TRANSPOSE(1'b1), .ROW_W(ROW_W), .CNT_W(CNT_W)
    ) u_tile_b (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .we_i     (load_we && load_sel_i),
        .row_i    (load_row_i),
        .data_i   (load_data_i),
        .clr_i    (clr),
        .t_i      (cnt_d),
        .loaded_o (loaded_b),
        .diag_o   (diag_b)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i && (&loaded_a) && (&loaded_b)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs register the upcoming state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            inputs_valid_o <= 1'b0;
            load_ready_o   <= 1'b1;
            for (int i = 0; i < N; i++) begin
                west_o[i]  <= '0;
                north_o[i] <= '0;
            end
        end else begin
            busy_o         <= (state_d == STREAM);
            done_o         <= (state_d == DONE);
            inputs_valid_o <= (state_d == STREAM);
            load_ready_o   <= (state_d == IDLE);
            for (int i = 0; i < N; i++) begin
                west_o[i]  <= (state_d == STREAM) ? diag_a[i] : '0;
                north_o[i] <= (state_d == STREAM) ? diag_b[i] : '0;
            end
        end
    end

endmodule
